// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: three-state fetch FSM (IDLE/REQ/DONE) owning PC and IR,
// with a bounded memory wait and a sticky FAULT for timeouts and phase-protocol errors.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          TIMEOUT      = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FETCH,
    input  logic        DECODE,
    input  logic        EXECUTE,
    input  logic        COMMIT,
    input  logic        MEM_RDY,
    input  logic [15:0] MEM_DIN,
    input  logic        PC_LOAD,
    input  logic [15:0] PC_NEXT,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RD,
    output logic [15:0] IR,
    output logic [15:0] PC,
    output logic        STALL,
    output logic        FAULT
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          proto_err;
    assign proto_err = ($countones({FETCH, DECODE, EXECUTE, COMMIT}) > 1)
                     | (FETCH && state != IDLE) | (COMMIT && state != DONE);
    assign STALL = state == REQ;
    // A protocol error freezes everything but FAULT; the offending strobes are dropped.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            PC       <= RESET_VECTOR;
            IR       <= 16'h0000;
            MEM_ADDR <= 16'h0000;
            MEM_RD   <= 1'b0;
            FAULT    <= 1'b0;
            wait_cnt <= '0;
        end else if (proto_err) begin
            FAULT <= 1'b1;
        end else begin
            case (state)
                IDLE: if (FETCH) begin
                    MEM_RD   <= 1'b1;
                    MEM_ADDR <= PC;
                    wait_cnt <= '0;
                    state    <= REQ;
                end
                REQ: if (MEM_RDY) begin
                    IR     <= MEM_DIN;
                    MEM_RD <= 1'b0;
                    state  <= DONE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    IR     <= 16'h0000;
                    MEM_RD <= 1'b0;
                    FAULT  <= 1'b1;
                    state  <= DONE;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                DONE: if (COMMIT) begin
                    PC    <= PC_LOAD ? PC_NEXT : PC + 16'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed and randomized instruction cycles against a
// phase-level model of PC, IR and FAULT.
module tb_instruction_fetch_unit;
    localparam logic [15:0] RV = 16'h0000;
    localparam int TMO = 8;
    logic        CLK = 0, RESET = 1;
    logic        FETCH = 0, DECODE = 0, EXECUTE = 0, COMMIT = 0, MEM_RDY = 0, PC_LOAD = 0;
    logic [15:0] MEM_DIN = 0, PC_NEXT = 0;
    logic [15:0] MEM_ADDR, IR, PC;
    logic        MEM_RD, STALL, FAULT;
    int vec = 0, errs = 0;
    logic [15:0] m_pc, m_ir;
    logic        m_fault;

    instruction_fetch_unit #(.RESET_VECTOR(RV), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE),
        .COMMIT(COMMIT), .MEM_RDY(MEM_RDY), .MEM_DIN(MEM_DIN), .PC_LOAD(PC_LOAD),
        .PC_NEXT(PC_NEXT), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .IR(IR), .PC(PC),
        .STALL(STALL), .FAULT(FAULT));

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input logic f, d, e, c);
        {FETCH, DECODE, EXECUTE, COMMIT} = {f, d, e, c};
        tick();
        {FETCH, DECODE, EXECUTE, COMMIT} = 4'b0;
    endtask

    task automatic test_reset;
        RESET = 1;
        tick();
        tick();
        RESET = 0;
        m_pc = RV; m_ir = 16'h0000; m_fault = 0;
        vec++;
        if ({PC, IR, MEM_ADDR, MEM_RD, FAULT, STALL} !== {RV, 16'h0000, 16'h0000, 3'b000}) begin
            errs++;
            $display("FAIL reset: pc=%h ir=%h addr=%h rd=%b fault=%b stall=%b, want pc=%h rest 0",
                     PC, IR, MEM_ADDR, MEM_RD, FAULT, STALL, RV);
        end
    endtask

    // One FETCH/DECODE/EXECUTE/COMMIT cycle; memory answers after `delay` wait cycles.
    task automatic full_cycle(input int delay, input logic [15:0] din, input logic ld,
                              input logic [15:0] nxt);
        int n = 0;
        int exp_n = (delay < TMO) ? delay + 1 : TMO;
        logic [15:0] addr = m_pc;
        strobe(1, 0, 0, 0);
        while (STALL && n < 40) begin
            MEM_RDY = (n == delay);
            MEM_DIN = MEM_RDY ? din : 16'($urandom);
            vec++;
            if (MEM_RD !== 1'b1 || MEM_ADDR !== addr) begin
                errs++;
                $display("FAIL req_hold: rd=%b addr=%h, want rd=1 addr=%h", MEM_RD, MEM_ADDR, addr);
            end
            tick();
            n++;
        end
        MEM_RDY = 0;
        m_ir = (delay < TMO) ? din : 16'h0000;
        m_fault = m_fault | (delay >= TMO);
        vec++;
        if (n != exp_n || MEM_RD !== 1'b0 || IR !== m_ir || FAULT !== m_fault) begin
            errs++;
            $display("FAIL fetch: stall_cycles=%0d rd=%b ir=%h fault=%b, want %0d 0 %h %b",
                     n, MEM_RD, IR, FAULT, exp_n, m_ir, m_fault);
        end
        PC_LOAD = 1; PC_NEXT = 16'($urandom); MEM_RDY = 1; MEM_DIN = ~din;
        strobe(0, 1, 0, 0);
        strobe(0, 0, 1, 0);
        MEM_RDY = 0;
        vec++;
        if (PC !== m_pc || IR !== m_ir || STALL !== 1'b0) begin
            errs++;
            $display("FAIL decode_execute_hold: pc=%h ir=%h stall=%b, want %h %h 0", PC, IR, STALL, m_pc, m_ir);
        end
        PC_LOAD = ld; PC_NEXT = nxt;
        strobe(0, 0, 0, 1);
        PC_LOAD = 0;
        m_pc = ld ? nxt : 16'((32'(m_pc) + 1) % 65536);
        vec++;
        if (PC !== m_pc || FAULT !== m_fault) begin
            errs++;
            $display("FAIL commit: pc=%h fault=%b, want %h %b", PC, FAULT, m_pc, m_fault);
        end
    endtask

    task automatic test_basic;
        full_cycle(0, 16'hA5C3, 0, 16'h0000);
    endtask

    task automatic test_delay;
        full_cycle(3, 16'h3C5A, 0, 16'h0000);
        full_cycle(TMO - 1, 16'h7E81, 0, 16'h0000);
    endtask

    task automatic test_timeout;
        full_cycle(1000, 16'hFFFF, 0, 16'h0000);
        full_cycle(0, 16'h1111, 0, 16'h0000);
        test_reset();
    endtask

    task automatic test_wrap;
        full_cycle(0, 16'h2222, 1, 16'hFFFF);
        full_cycle(1, 16'h3333, 0, 16'h0000);
        full_cycle(2, 16'h4444, 1, 16'h1234);
    endtask

    task automatic test_protocol;
        full_cycle(0, 16'h5A5A, 0, 16'h0000);
        strobe(1, 1, 0, 0);
        vec++;
        if (FAULT !== 1'b1 || PC !== m_pc || IR !== m_ir || STALL !== 1'b0 || MEM_RD !== 1'b0) begin
            errs++;
            $display("FAIL multi_strobe: fault=%b pc=%h ir=%h stall=%b rd=%b, want 1 %h %h 0 0",
                     FAULT, PC, IR, STALL, MEM_RD, m_pc, m_ir);
        end
        test_reset();
        full_cycle(0, 16'h6B6B, 0, 16'h0000);
        PC_LOAD = 1; PC_NEXT = 16'hBEEF;
        strobe(0, 0, 0, 1);
        PC_LOAD = 0;
        vec++;
        if (FAULT !== 1'b1 || PC !== m_pc || IR !== m_ir) begin
            errs++;
            $display("FAIL commit_in_idle: fault=%b pc=%h ir=%h, want 1 %h %h", FAULT, PC, IR, m_pc, m_ir);
        end
        test_reset();
    endtask

    task automatic test_reset_in_req;
        full_cycle(0, 16'hC0DE, 0, 16'h0000);
        strobe(1, 0, 0, 0);
        tick();
        RESET = 1;
        tick();
        RESET = 0; MEM_RDY = 1; MEM_DIN = 16'hBEEF;
        tick();
        MEM_RDY = 0;
        m_pc = RV; m_ir = 16'h0000; m_fault = 0;
        vec++;
        if (MEM_RD !== 1'b0 || IR !== 16'h0000 || PC !== RV || STALL !== 1'b0 || FAULT !== 1'b0) begin
            errs++;
            $display("FAIL reset_in_req: rd=%b ir=%h pc=%h stall=%b fault=%b, want 0 0000 %h 0 0",
                     MEM_RD, IR, PC, STALL, FAULT, RV);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            full_cycle(int'($urandom_range(0, TMO + 2)), 16'($urandom), 1'($urandom), 16'($urandom));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delay();
        test_timeout();
        test_wrap();
        test_protocol();
        test_reset_in_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
